task3_line_fsm: RTL and testbench
=================================

Name: task3_line_fsm

Overview:
- Framebuffer-drawing controller for the 160x120 VGA pixel-write port.
- After reset it clears the screen to black, one pixel per clock.
- Each key press then draws a straight line in `input_color` from the previous endpoint to (`x1`,`y1`) using Bresenham's algorithm, one pixel per clock.
- It sits between user controls (switches/key) and the VGA adapter's pixel-write interface.

Parameters:
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are never written.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are never written.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- key  in  1  draw request; level input, rising edge detected internally.
- x1  in  9  line endpoint x (unsigned).
- y1  in  9  line endpoint y (unsigned).
- input_color  in  3  line colour.
- x_out  out  9  pixel x to VGA.
- y_out  out  9  pixel y to VGA.
- write_out  out  1  VGA pixel write enable; one pixel per high cycle.
- color  out  3  pixel colour to VGA.

Behaviour:
- All outputs are registered.
- While reset=1: state<=CLEAR, x_out=0, y_out=0, write_out=0, color=0, previous endpoint (px,py)<=(0,0), key edge register<=0.
- Key edge detection:
  - key_q registered every cycle; edge = key & ~key_q.
  - An edge is acted on only in IDLE. Edges in any other state are discarded, not queued.
- States: CLEAR, IDLE, INIT, DRAW.
- CLEAR:
  - Starting the first cycle after reset deasserts, emit (x,y,color=0,write_out=1) in raster order: x inner 0..159, y outer 0..119.
  - That is exactly SCREEN_W*SCREEN_H = 19200 consecutive write cycles; the last pixel is (159,119).
  - Next state is IDLE, with write_out=0.
- IDLE: write_out=0, other outputs hold. On edge, go to INIT.
- INIT (one cycle, write_out=0):
  - Latch x1, y1, input_color.
  - Set cur=(px,py), dx=|x1-px|, dy=-|y1-py|.
  - sx=+1 if px<x1 else -1; sy=+1 if py<y1 else -1; err=dx+dy.
  - Use 11-bit signed arithmetic; no overflow is possible for 9-bit coordinates.
  - The first pixel therefore appears 2 cycles after the cycle in which the edge is seen.
- DRAW (one pixel per cycle):
  - Output x_out=cur.x, y_out=cur.y, color=latched colour.
  - write_out=1 iff cur.x<SCREEN_W and cur.y<SCREEN_H; off-screen pixels are skipped silently but still consume a cycle.
  - If cur==(x1,y1) after emitting: (px,py)<=(x1,y1), go to IDLE.
  - Otherwise: e2=2*err; if e2>=dy then err+=dy, cur.x+=sx; if e2<=dx then err+=dx, cur.y+=sy. Both updates use the old err and apply in the same cycle.
  - Both endpoints are included, so a line produces max(|dx|,|dy|)+1 DRAW cycles.
  - A zero-length line (endpoint equals previous endpoint) emits exactly one pixel.
- Changes to x1/y1/input_color after INIT do not affect the line in progress.
- Reset asserted mid-CLEAR or mid-DRAW aborts immediately and restarts CLEAR. The previous endpoint returns to (0,0).
- Outputs during IDLE hold the last drawn pixel's coordinates/colour with write_out=0.

Test Plan:
- Reset pulse then release → exactly 19200 consecutive write_out=1 cycles, colour 0, first (0,0), second (1,0), 160th (159,0), last (159,119); then write_out stays 0.
- After clear, x1=10,y1=10,input_color=1, key high 5 cycles → write_out high 2 cycles after edge; 11 pixels (0,0),(1,1)…(10,10), colour 1; one line only despite key held.
- Then x1=105,y1=9,input_color=3, key pulse → 96 pixels from (10,10) to (105,9):
  - x increments by 1 each cycle.
  - y changes from 10 to 9 exactly once.
  - colour 3 throughout.
  - Changing input_color to 4 mid-line leaves colour 3.
- Key edge during CLEAR or DRAW → ignored; no extra line after the current operation completes.
- Reverse/steep line: previous endpoint (10,10), target (7,20) → 11 pixels, y strictly +1 per cycle, x non-increasing, ends at (7,20).
- Off-screen clip: target (200,5) from (0,0) → 201 DRAW cycles, write_out=1 only for x<160; the next line then starts from (200,5). Reset asserted mid-line → next cycles restart CLEAR at (0,0).

Source files
------------

// File: rtl/task3_line_fsm.sv
// Framebuffer line-drawing controller: clears the 160x120 screen after reset, then draws
// one Bresenham line per key press from the previous endpoint, one pixel per clock.
module task3_line_fsm #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    input  logic [8:0] x1,
    input  logic [8:0] y1,
    input  logic [2:0] input_color,
    output logic [8:0] x_out,
    output logic [8:0] y_out,
    output logic       write_out,
    output logic [2:0] color
);

    localparam int unsigned CW = 9;
    localparam int unsigned AW = 11;
    localparam int unsigned KW = 3;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_INIT  = 2'd2;
    localparam logic [1:0] S_DRAW  = 2'd3;

    logic [1:0]           r_state, w_state_n;
    logic                 r_key_q;
    logic [CW-1:0]        r_x_out, w_x_out_n;
    logic [CW-1:0]        r_y_out, w_y_out_n;
    logic                 r_wr, w_wr_n;
    logic [KW-1:0]        r_color, w_color_n;
    logic [CW-1:0]        r_px, w_px_n;
    logic [CW-1:0]        r_py, w_py_n;
    logic [CW-1:0]        r_tx, w_tx_n;
    logic [CW-1:0]        r_ty, w_ty_n;
    logic [KW-1:0]        r_lcol, w_lcol_n;
    logic [AW-1:0]        r_cx, w_cx_n;
    logic [AW-1:0]        r_cy, w_cy_n;
    logic signed [AW-1:0] r_dx, w_dx_n;
    logic signed [AW-1:0] r_dy, w_dy_n;
    logic signed [AW-1:0] r_err, w_err_n;
    logic                 r_sx_neg, w_sx_neg_n;
    logic                 r_sy_neg, w_sy_neg_n;
    logic [CW-1:0]        r_clr_x, w_clr_x_n;
    logic [CW-1:0]        r_clr_y, w_clr_y_n;

    logic                 w_edge;
    logic signed [AW-1:0] w_dxs;
    logic signed [AW-1:0] w_dys;
    logic signed [AW-1:0] w_dx_abs;
    logic signed [AW-1:0] w_dy_nabs;
    logic signed [AW:0]   w_e2;
    logic signed [AW:0]   w_dx_w;
    logic signed [AW:0]   w_dy_w;
    logic                 w_step_x;
    logic                 w_step_y;
    logic                 w_on_screen;
    logic                 w_at_end;

    assign w_edge    = key & ~r_key_q;
    assign w_dxs     = $signed(AW'(x1)) - $signed(AW'(r_px));
    assign w_dys     = $signed(AW'(y1)) - $signed(AW'(r_py));
    assign w_dx_abs  = w_dxs[AW-1] ? -w_dxs : w_dxs;
    assign w_dy_nabs = w_dys[AW-1] ? w_dys : -w_dys;

    // Bresenham decision terms, widened one bit so 2*err cannot wrap.
    assign w_e2        = {r_err, 1'b0};
    assign w_dx_w      = {r_dx[AW-1], r_dx};
    assign w_dy_w      = {r_dy[AW-1], r_dy};
    assign w_step_x    = (w_e2 >= w_dy_w);
    assign w_step_y    = (w_e2 <= w_dx_w);
    assign w_on_screen = (r_cx < AW'(SCREEN_W)) && (r_cy < AW'(SCREEN_H));
    assign w_at_end    = (r_cx == AW'(r_tx)) && (r_cy == AW'(r_ty));

    // Next-state and next-output logic.
    always_comb begin
        w_state_n  = r_state;
        w_x_out_n  = r_x_out;
        w_y_out_n  = r_y_out;
        w_wr_n     = 1'b0;
        w_color_n  = r_color;
        w_px_n     = r_px;
        w_py_n     = r_py;
        w_tx_n     = r_tx;
        w_ty_n     = r_ty;
        w_lcol_n   = r_lcol;
        w_cx_n     = r_cx;
        w_cy_n     = r_cy;
        w_dx_n     = r_dx;
        w_dy_n     = r_dy;
        w_err_n    = r_err;
        w_sx_neg_n = r_sx_neg;
        w_sy_neg_n = r_sy_neg;
        w_clr_x_n  = r_clr_x;
        w_clr_y_n  = r_clr_y;

        case (r_state)
            S_CLEAR: begin
                w_x_out_n = r_clr_x;
                w_y_out_n = r_clr_y;
                w_color_n = '0;
                w_wr_n    = 1'b1;
                if (r_clr_x == CW'(SCREEN_W - 1)) begin
                    w_clr_x_n = '0;
                    if (r_clr_y == CW'(SCREEN_H - 1)) begin
                        w_clr_y_n = '0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_clr_y_n = r_clr_y + CW'(1);
                    end
                end else begin
                    w_clr_x_n = r_clr_x + CW'(1);
                end
            end
            S_IDLE: begin
                if (w_edge) w_state_n = S_INIT;
            end
            S_INIT: begin
                w_tx_n     = x1;
                w_ty_n     = y1;
                w_lcol_n   = input_color;
                w_cx_n     = AW'(r_px);
                w_cy_n     = AW'(r_py);
                w_dx_n     = w_dx_abs;
                w_dy_n     = w_dy_nabs;
                w_err_n    = w_dx_abs + w_dy_nabs;
                w_sx_neg_n = !(r_px < x1);
                w_sy_neg_n = !(r_py < y1);
                w_state_n  = S_DRAW;
            end
            S_DRAW: begin
                w_x_out_n = r_cx[CW-1:0];
                w_y_out_n = r_cy[CW-1:0];
                w_color_n = r_lcol;
                w_wr_n    = w_on_screen;
                if (w_at_end) begin
                    w_px_n    = r_tx;
                    w_py_n    = r_ty;
                    w_state_n = S_IDLE;
                end else begin
                    // Both axis updates use the pre-step error term.
                    w_err_n = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
                    if (w_step_x) w_cx_n = r_cx + (r_sx_neg ? {AW{1'b1}} : AW'(1));
                    if (w_step_y) w_cy_n = r_cy + (r_sy_neg ? {AW{1'b1}} : AW'(1));
                end
            end
            default: w_state_n = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_CLEAR;
            r_key_q  <= 1'b0;
            r_x_out  <= '0;
            r_y_out  <= '0;
            r_wr     <= 1'b0;
            r_color  <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_tx     <= '0;
            r_ty     <= '0;
            r_lcol   <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_clr_x  <= '0;
            r_clr_y  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_key_q  <= key;
            r_x_out  <= w_x_out_n;
            r_y_out  <= w_y_out_n;
            r_wr     <= w_wr_n;
            r_color  <= w_color_n;
            r_px     <= w_px_n;
            r_py     <= w_py_n;
            r_tx     <= w_tx_n;
            r_ty     <= w_ty_n;
            r_lcol   <= w_lcol_n;
            r_cx     <= w_cx_n;
            r_cy     <= w_cy_n;
            r_dx     <= w_dx_n;
            r_dy     <= w_dy_n;
            r_err    <= w_err_n;
            r_sx_neg <= w_sx_neg_n;
            r_sy_neg <= w_sy_neg_n;
            r_clr_x  <= w_clr_x_n;
            r_clr_y  <= w_clr_y_n;
        end
    end

    assign x_out     = r_x_out;
    assign y_out     = r_y_out;
    assign write_out = r_wr;
    assign color     = r_color;

endmodule

// File: tb/tb_task3_line_fsm.sv
// Directed bench for task3_line_fsm: screen clear, a table of lines with hand-computed
// pixel counts and shapes, ignored key edges, clipping and mid-line reset.
module tb_task3_line_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic [8:0] x1;
    logic [8:0] y1;
    logic [2:0] input_color;
    logic [8:0] x_out;
    logic [8:0] y_out;
    logic       write_out;
    logic [2:0] color;

    task3_line_fsm dut (
        .clk(clk), .reset(reset), .key(key), .x1(x1), .y1(y1),
        .input_color(input_color), .x_out(x_out), .y_out(y_out),
        .write_out(write_out), .color(color)
    );

    always #5 clk = ~clk;

    // shape: 0 none, 1 diagonal from origin, 2 x+1 per pixel with one y change, 3 y+1 per pixel with x non-increasing
    typedef struct {
        int tx; int ty; int c;
        int hold; int glitch; int colchg;
        int n; int nw; int fx; int fy; int fw; int shape;
    } vec_t;

    vec_t tbl[8];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   qx[$];
    int   qy[$];
    int   qw[$];
    int   qc[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic check_clear(input string tag, input int glitch);
        int cnt = 0;
        int order_bad = 0;
        int col_bad = 0;
        int first_s = -1;
        int lx = 0;
        int ly = 0;
        int x2 = -1;
        int x160 = -1;
        int post_bad = 0;
        bit done = 0;
        for (int s = 0; s < 19400 && !done; s++) begin
            @(negedge clk);
            if (glitch > 0 && s == glitch) key = 1'b1;
            if (glitch > 0 && s == glitch + 1) key = 1'b0;
            if (write_out) begin
                if (first_s < 0) first_s = s;
                if (int'(x_out) != cnt % 160 || int'(y_out) != cnt / 160) order_bad++;
                if (color != 3'd0) col_bad++;
                if (cnt == 1) x2 = int'(x_out);
                if (cnt == 159) x160 = int'(x_out);
                lx = int'(x_out);
                ly = int'(y_out);
                cnt++;
            end else if (cnt > 0) begin
                done = 1;
            end
        end
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            if (write_out) post_bad++;
        end
        chk({tag, "_first_cycle"}, first_s, 0);
        chk({tag, "_count"}, cnt, 19200);
        chk({tag, "_raster_order"}, order_bad, 0);
        chk({tag, "_colour"}, col_bad, 0);
        chk({tag, "_second_x"}, x2, 1);
        chk({tag, "_160th_x"}, x160, 159);
        chk({tag, "_last_x"}, lx, 159);
        chk({tag, "_last_y"}, ly, 119);
        chk({tag, "_idle_after"}, post_bad, 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int  pre_w = 0;
        int  nw = 0;
        int  col_bad = 0;
        int  shape_bad = 0;
        int  ychg = 0;
        int  post_bad = 0;
        bit  found = 0;
        qx.delete(); qy.delete(); qw.delete(); qc.delete();
        x1 = 9'(v.tx);
        y1 = 9'(v.ty);
        input_color = 3'(v.c);
        key = 1'b1;
        for (int s = 1; s <= 1000 && !found; s++) begin
            @(negedge clk);
            if (s < 3) begin
                if (write_out) pre_w++;
            end else begin
                qx.push_back(int'(x_out));
                qy.push_back(int'(y_out));
                qw.push_back(int'(write_out));
                qc.push_back(int'(color));
                if (int'(x_out) == v.tx && int'(y_out) == v.ty) found = 1;
            end
            if (s == v.hold) key = 1'b0;
            if (v.glitch > 0 && s == v.glitch) key = 1'b1;
            if (v.glitch > 0 && s == v.glitch + 1) key = 1'b0;
            if (v.colchg > 0 && s == v.colchg) input_color = 3'd4;
        end
        key = 1'b0;
        for (int i = 0; i < qx.size(); i++) begin
            nw += qw[i];
            if (qc[i] != v.c) col_bad++;
            if (v.shape == 1 && (qx[i] != i || qy[i] != i)) shape_bad++;
            if (v.shape == 2) begin
                if (qx[i] != qx[0] + i) shape_bad++;
                if (i > 0 && qy[i] != qy[i-1]) ychg++;
            end
            if (v.shape == 3) begin
                if (qy[i] != qy[0] + i) shape_bad++;
                if (i > 0 && qx[i] > qx[i-1]) shape_bad++;
            end
        end
        if (v.shape == 2 && ychg != 1) shape_bad++;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (write_out || int'(x_out) != v.tx || int'(y_out) != v.ty) post_bad++;
        end
        chk({tag, "_reached_end"}, int'(found), 1);
        chk({tag, "_no_early_write"}, pre_w, 0);
        chk({tag, "_draw_cycles"}, qx.size(), v.n);
        chk({tag, "_writes"}, nw, v.nw);
        chk({tag, "_first_x"}, qx[0], v.fx);
        chk({tag, "_first_y"}, qy[0], v.fy);
        chk({tag, "_first_write"}, qw[0], v.fw);
        chk({tag, "_colour"}, col_bad, 0);
        if (v.shape != 0) chk({tag, "_shape"}, shape_bad, 0);
        chk({tag, "_idle_after"}, post_bad, 0);
    endtask

    initial begin
        //             tx   ty  c hold glt cc   n   nw  fx   fy fw shape
        tbl[0] = '{ 10,  10, 1, 5,   0,  0,  11,  11,  0,   0, 1, 1};
        tbl[1] = '{105,   9, 3, 1,  50, 40,  96,  96, 10,  10, 1, 2};
        tbl[2] = '{ 10,  10, 2, 1,   0,  0,  96,  96, 105,  9, 1, 0};
        tbl[3] = '{  7,  20, 5, 1,   0,  0,  11,  11, 10,  10, 1, 3};
        tbl[4] = '{  7,  20, 6, 1,   0,  0,   1,   1,  7,  20, 1, 0};
        tbl[5] = '{  0,   0, 7, 1,   0,  0,  21,  21,  7,  20, 1, 0};
        tbl[6] = '{200,   5, 1, 1,   0,  0, 201, 160,  0,   0, 1, 0};
        tbl[7] = '{150,   5, 2, 1,   0,  0,  51,  10, 200,  5, 0, 0};

        reset = 1'b1;
        key = 1'b0;
        x1 = '0;
        y1 = '0;
        input_color = '0;
        repeat (3) @(negedge clk);
        chk("reset_write", int'(write_out), 0);
        chk("reset_x", int'(x_out), 0);
        chk("reset_y", int'(y_out), 0);
        chk("reset_colour", int'(color), 0);
        reset = 1'b0;
        check_clear("clear0", 0);

        for (int i = 0; i < 8; i++) run_vec($sformatf("line%0d", i), tbl[i]);

        // Reset in the middle of a long line aborts it and restarts the clear.
        x1 = 9'd0;
        y1 = 9'd0;
        input_color = 3'd3;
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
        repeat (20) @(negedge clk);
        chk("midline_drawing", int'(write_out), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_write", int'(write_out), 0);
        chk("midrst_x", int'(x_out), 0);
        chk("midrst_y", int'(y_out), 0);
        chk("midrst_colour", int'(color), 0);
        reset = 1'b0;
        check_clear("clear1", 100);

        // Previous endpoint must be back at the origin.
        run_vec("post_reset", '{3, 0, 2, 1, 0, 0, 4, 4, 0, 0, 1, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
